sram_controller: RTL and testbench
==================================

# sram_controller

Bridges the processor's 32-bit memory stage to the 16-bit external SRAM. Each word read or write becomes two 16-bit SRAM accesses, low half first. While an access is in progress the block holds `ready` low, and the pipeline freezes on it. The block sits directly upstream of the SRAM: it drives the SRAM address and control pins and owns the shared `SRAM_DQ` bus.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: the processor data address that maps to SRAM word 0.
- `ADDR_W`, default 18: width of the SRAM address.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rd_en`, input, 1: word read request; held high until `ready`.
- `wr_en`, input, 1: word write request; held high until `ready`.
- `address`, input, 32: processor byte address; bits [1:0] ignored.
- `write_data`, input, 32: word to write.
- `byte_en`, input, 4: byte-lane enables. Present only with `SRAM_CTRL_BYTE_EN`.
- `read_data`, output, 32: registered read word.
- `ready`, output, 1: pipeline may advance.
- `SRAM_DQ`, inout, 16: bidirectional SRAM data.
- `SRAM_ADDR`, output, 18: SRAM halfword address.
- `SRAM_UB_N`, `SRAM_LB_N`, output, 1 each: byte-lane enables, active low.
- `SRAM_WE_N`, output, 1: write enable, active low.
- `SRAM_CE_N`, `SRAM_OE_N`, output, 1 each: tied to 0.

## Operation
- **Address map:** `off = address - BASE_ADDR`. The low halfword is at `{off[18:2],1'b0}` and the high halfword at `{off[18:2],1'b1}`. Truncate to 18 bits with no range check.
- **Request priority:** if `wr_en` and `rd_en` are both high, the write wins.
- **FSM states:** IDLE, W_LO, W_HI, R_LO, R_HI, R_CAP, DONE.
- **IDLE:**
  - On `wr_en`, latch address and data and go to W_LO.
  - Otherwise, on `rd_en`, latch the address and go to R_LO.
  - Otherwise stay in IDLE.
- **W_LO:** `SRAM_WE_N=0`, `SRAM_ADDR` = low halfword address, drive `write_data[15:0]` on DQ. Go to W_HI.
- **W_HI:** `SRAM_WE_N=0`, `SRAM_ADDR` = high halfword address, drive `write_data[31:16]` on DQ. Go to DONE.
- **R_LO:** `SRAM_WE_N=1`, `SRAM_ADDR` = low halfword address, DQ released (Z). Go to R_HI.
- **R_HI:** `SRAM_ADDR` = high halfword address. Capture `SRAM_DQ` into `read_data[15:0]` at the clock edge. Go to R_CAP.
- **R_CAP:** capture `SRAM_DQ` into `read_data[31:16]` at the clock edge. Go to DONE.
- **DONE:** `ready=1` for exactly one cycle, then go to IDLE unconditionally. A request present in that cycle is not accepted until IDLE.
- **`ready` equation:** `ready = (state==IDLE && !rd_en && !wr_en) || state==DONE`, which is combinational. `ready` is therefore low in the same cycle a request is raised.
- **Between requests:** `read_data` holds its value until the next read capture.
- **DQ ownership:** DQ is driven only in W_LO and W_HI. In every other state and during reset it is Z.

## Timing
- **Write latency:** 3 cycles from request to `ready` (W_LO, W_HI, DONE).
- **Read latency:** 4 cycles from request to `ready` (R_LO, R_HI, R_CAP, DONE).
- **Read data valid:** `read_data` is valid from the start of DONE.
- **SRAM read timing:** one-cycle registered latency. Data for the address presented in cycle N appears on DQ in cycle N+1.
- **Reset values:**
  - state = IDLE, `read_data` = 0, `SRAM_WE_N` = 1, `SRAM_ADDR` = 0, DQ = Z.
  - `SRAM_UB_N` = `SRAM_LB_N` = 0; `SRAM_CE_N` = `SRAM_OE_N` = 0.
  - `ready` follows its equation.
- **Reset mid-access:** asynchronous. The FSM returns to IDLE immediately and `SRAM_WE_N` goes high in the same instant. A partially written word is left as-is.
- **Request dropped mid-access:** the access completes regardless and reaches DONE.

## Configuration
- **`SRAM_CTRL_BYTE_EN` defined:**
  - The `byte_en` port exists and is latched with the request.
  - In W_LO: `SRAM_LB_N=!byte_en[0]`, `SRAM_UB_N=!byte_en[1]`.
  - In W_HI: `SRAM_LB_N=!byte_en[2]`, `SRAM_UB_N=!byte_en[3]`.
  - Reads always use both lanes (both enables 0).
- **`SRAM_CTRL_BYTE_EN` undefined:** no `byte_en` port; `SRAM_UB_N=SRAM_LB_N=0` always, so all writes are full-word.

## Structure
- **Package `sram_ctrl_pkg`:** state enum `sram_ctrl_state_t`, default `BASE_ADDR` constant, the halfword-select encoding.
- **Sub-module `sram_addr_map`:** combinational. Takes `address` and the half-select and produces `SRAM_ADDR`. The FSM, latches and DQ tri-state stay in `sram_controller`.

## Test plan
1. **Write then read:** write `0xDEADBEEF` to address 1024, then read 1024. Required: SRAM halfword 0 = `0xBEEF`, halfword 1 = `0xDEAD`; read returns `0xDEADBEEF` with `ready` high in cycle 4 of the read.
2. **Address map:** read at address 1032. Required: `SRAM_ADDR` = 4 in R_LO and 5 in R_HI.
3. **Simultaneous request:** `rd_en=wr_en=1`, `write_data=0x12345678`. Required: write path taken; no R_* state visited.
4. **Reset mid-write:** assert `rst_n=0` in W_HI. Required: immediately `SRAM_WE_N=1`, DQ=Z, `read_data=0`, state IDLE; halfword 1 is unchanged.
5. **Byte enables (with `SRAM_CTRL_BYTE_EN`):** `byte_en=4'b0001`, write `0xAABBCCDD` over stored `0x11223344`. Required: subsequent read returns `0x112233DD`.
6. **Back-to-back requests:** hold `rd_en` across two reads. Required: `ready` high exactly one cycle per access; no access accepted in DONE.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the 32-to-16 bit SRAM bridge
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_LO,
    W_HI,
    R_LO,
    R_HI,
    R_CAP,
    DONE
  } sram_ctrl_state_t;

  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

  // Halfword select: appended as SRAM address bit 0
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_addr_map.sv
// rtl/sram_addr_map.sv - maps a processor byte address and halfword select to an SRAM halfword address
module sram_addr_map
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          ADDR_W    = 18
) (
  input  logic [31:0]       address,
  input  logic              half_sel,
  output logic [ADDR_W-1:0] sram_addr
);

  logic [31:0] off;
  logic        unused_off;

  // Word offset is truncated to the SRAM range; no range check by design
  assign off        = address - BASE_ADDR;
  assign sram_addr  = {off[ADDR_W:2], half_sel};
  assign unused_off = ^{off[31:ADDR_W+1], off[1:0]};

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit word access bridge to 16-bit SRAM; SRAM_CTRL_BYTE_EN adds byte-lane writes
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          ADDR_W    = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
`ifdef SRAM_CTRL_BYTE_EN
  input  logic [3:0]        byte_en,
`endif
  output logic [31:0]       read_data,
  output logic              ready,
  inout  wire  [15:0]       SRAM_DQ,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N
);

  sram_ctrl_state_t  state, next_state;
  logic [31:0]       addr_q, wdata_q;
  logic              half_sel, addr_active, drive_dq;
  logic [15:0]       dq_out;
  logic [ADDR_W-1:0] mapped_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (wr_en)      next_state = W_LO;
        else if (rd_en) next_state = R_LO;
      end
      W_LO:    next_state = W_HI;
      W_HI:    next_state = DONE;
      R_LO:    next_state = R_HI;
      R_HI:    next_state = R_CAP;
      R_CAP:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request fields track the inputs while idle; the value at the accepting edge is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE) begin
      addr_q  <= address;
      wdata_q <= write_data;
    end
  end

  // SRAM returns data one cycle after the address, so each half lands a state later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               read_data         <= '0;
    else if (state == R_HI)   read_data[15:0]   <= SRAM_DQ;
    else if (state == R_CAP)  read_data[31:16]  <= SRAM_DQ;
  end

  always_comb begin
    SRAM_WE_N   = 1'b1;
    half_sel    = HALF_LO;
    addr_active = 1'b0;
    drive_dq    = 1'b0;
    dq_out      = wdata_q[15:0];
    case (state)
      W_LO: begin
        SRAM_WE_N   = 1'b0;
        addr_active = 1'b1;
        drive_dq    = 1'b1;
      end
      W_HI: begin
        SRAM_WE_N   = 1'b0;
        half_sel    = HALF_HI;
        addr_active = 1'b1;
        drive_dq    = 1'b1;
        dq_out      = wdata_q[31:16];
      end
      R_LO: addr_active = 1'b1;
      R_HI: begin
        half_sel    = HALF_HI;
        addr_active = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SRAM_CTRL_BYTE_EN
  logic [3:0] be_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              be_q <= '0;
    else if (state == IDLE)  be_q <= byte_en;
  end

  always_comb begin
    SRAM_LB_N = 1'b0;
    SRAM_UB_N = 1'b0;
    if (state == W_LO) begin
      SRAM_LB_N = !be_q[0];
      SRAM_UB_N = !be_q[1];
    end else if (state == W_HI) begin
      SRAM_LB_N = !be_q[2];
      SRAM_UB_N = !be_q[3];
    end
  end
`else
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
`endif

  sram_addr_map #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) u_addr_map (
    .address   (addr_q),
    .half_sel  (half_sel),
    .sram_addr (mapped_addr)
  );

  assign SRAM_ADDR = addr_active ? mapped_addr : '0;
  assign SRAM_DQ   = drive_dq ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign ready     = (state == IDLE && !rd_en && !wr_en) || state == DONE;

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller with a behavioural SRAM and word-level reference
module tb_sram_controller;

  localparam int unsigned BASE = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
`ifdef SRAM_CTRL_BYTE_EN
  logic [3:0]  byte_en = 4'hF;
`endif
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .ADDR_W(18)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
`ifdef SRAM_CTRL_BYTE_EN
    .byte_en    (byte_en),
`endif
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_UB_N  (SRAM_UB_N),
    .SRAM_LB_N  (SRAM_LB_N),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_CE_N  (SRAM_CE_N),
    .SRAM_OE_N  (SRAM_OE_N)
  );

  // Behavioural SRAM: registered read, byte-lane writes, drives only while not writing
  logic [15:0] sram_mem [0:255];
  logic [15:0] rd_q = '0;
  logic        rd_drv = 1'b0;
  logic        probe = 1'b0;

  assign SRAM_DQ = probe ? 16'h0000 : ((rd_drv && SRAM_WE_N) ? rd_q : 16'hzzzz);

  always @(posedge clk) begin
    rd_q   <= sram_mem[SRAM_ADDR[7:0]];
    rd_drv <= SRAM_WE_N;
    if (!SRAM_WE_N) begin
      if (!SRAM_LB_N) sram_mem[SRAM_ADDR[7:0]][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) sram_mem[SRAM_ADDR[7:0]][15:8] <= SRAM_DQ[15:8];
    end
  end

  // Word-level reference: word index -> 32-bit contents
  logic [31:0] ref_mem [int];
  logic [17:0] addr_tr [0:7];
  logic        we_tr   [0:7];

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) / 4) % 131072);
  endfunction

  function automatic logic [17:0] exp_half(input logic [31:0] a, input int hi);
    return 18'(widx(a) * 2 + hi);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
    wr_en = w;
    rd_en = r;
    address = a;
    write_data = d;
    lat = 0;
    #1;
    check("ready_low_on_request", ready, 0);
    while (!ready && lat < 12) begin
      step();
      lat++;
      if (lat < 8) begin
        addr_tr[lat] = SRAM_ADDR;
        we_tr[lat]   = SRAM_WE_N;
      end
    end
    rd = read_data;
    wr_en = 0;
    rd_en = 0;
    step();
  endtask

  initial begin
    int lat;
    int k;
    int op;
    logic [31:0] rd, prev, old_w, new_w, a, d;

    probe = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", read_data, 0);
    check("rst_we_n", SRAM_WE_N, 1);
    check("rst_sram_addr", SRAM_ADDR, 0);
    check("rst_lanes", {SRAM_UB_N, SRAM_LB_N}, 0);
    check("rst_ce_oe", {SRAM_CE_N, SRAM_OE_N}, 0);
    check("rst_dq_released", SRAM_DQ, 0);
    check("rst_ready", ready, 1);
    rst_n = 1;
    probe = 0;
    step();

    // Write then read word 0
    access(1, 0, BASE, 32'hDEADBEEF, lat, rd);
    ref_mem[0] = 32'hDEADBEEF;
    check("wr_latency", lat, 3);
    check("wr_lo_we", we_tr[1], 0);
    check("wr_hi_we", we_tr[2], 0);
    check("wr_lo_addr", addr_tr[1], 0);
    check("wr_hi_addr", addr_tr[2], 1);
    check("sram_hw0", sram_mem[0], 16'hBEEF);
    check("sram_hw1", sram_mem[1], 16'hDEAD);
    access(0, 1, BASE, 0, lat, rd);
    check("rd_latency", lat, 4);
    check("rd_data_word0", rd, 32'hDEADBEEF);

    for (int i = 1; i < 16; i++) begin
      d = $urandom;
      access(1, 0, BASE + 32'(4 * i), d, lat, rd);
      ref_mem[i] = d;
      check("prefill_latency", lat, 3);
    end

    // Address map at 1032
    access(0, 1, 32'd1032, 0, lat, rd);
    check("map_rlo_addr", addr_tr[1], exp_half(32'd1032, 0));
    check("map_rhi_addr", addr_tr[2], exp_half(32'd1032, 1));
    check("map_rlo_we", we_tr[1], 1);
    check("map_rd_data", rd, ref_mem[2]);

    // Simultaneous request: write wins, read_data holds
    prev = read_data;
    access(1, 1, BASE + 12, 32'h12345678, lat, rd);
    ref_mem[3] = 32'h12345678;
    check("both_latency", lat, 3);
    check("both_lo_we", we_tr[1], 0);
    check("both_hi_we", we_tr[2], 0);
    check("read_data_hold", read_data, prev);
    access(0, 1, BASE + 12, 0, lat, rd);
    check("both_readback", rd, 32'h12345678);

    // Back-to-back reads with rd_en held
    rd_en = 1;
    address = BASE + 20;
    #1;
    for (int c = 0; c < 10; c++) begin
      check("b2b_ready", ready, (c % 5 == 4) ? 1 : 0);
      if (c % 5 == 4) check("b2b_data", read_data, ref_mem[5]);
      step();
    end
    rd_en = 0;
    step();

    // Reset mid-write in W_HI
    old_w = ref_mem[7];
    new_w = {16'h5A5A ^ 16'($urandom_range(0, 255)), 16'hA5A5};
    wr_en = 1;
    address = BASE + 28;
    write_data = new_w;
    step();
    step();
    check("midwr_in_w_hi", {SRAM_WE_N, SRAM_ADDR}, {1'b0, exp_half(BASE + 28, 1)});
    probe = 1;
    rst_n = 0;
    #1;
    check("midwr_we_n", SRAM_WE_N, 1);
    check("midwr_dq_released", SRAM_DQ, 0);
    check("midwr_read_data", read_data, 0);
    check("midwr_addr", SRAM_ADDR, 0);
    wr_en = 0;
    #1;
    check("midwr_idle_ready", ready, 1);
    step();
    rst_n = 1;
    probe = 0;
    step();
    check("midwr_hi_unchanged", sram_mem[15], old_w[31:16]);
    check("midwr_lo_written", sram_mem[14], new_w[15:0]);
    ref_mem[7] = {old_w[31:16], new_w[15:0]};

    // Address below BASE wraps into the top of SRAM space
    access(0, 1, 32'd0, 0, lat, rd);
    check("wrap_lo_addr", addr_tr[1], exp_half(32'd0, 0));
    check("wrap_hi_addr", addr_tr[2], exp_half(32'd0, 1));

`ifdef SRAM_CTRL_BYTE_EN
    byte_en = 4'hF;
    access(1, 0, BASE + 36, 32'h11223344, lat, rd);
    byte_en = 4'b0001;
    access(1, 0, BASE + 36, 32'hAABBCCDD, lat, rd);
    byte_en = 4'hF;
    access(0, 1, BASE + 36, 0, lat, rd);
    check("byte_en_merge", rd, 32'h112233DD);
    ref_mem[9] = 32'h112233DD;
`endif

    // Randomized traffic against the word reference
    for (int n = 0; n < 30; n++) begin
      k  = $urandom_range(0, 15);
      op = $urandom_range(0, 2);
      a  = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
      d  = $urandom;
      if (op == 0) begin
        access(0, 1, a, 0, lat, rd);
        check("rand_rd_latency", lat, 4);
        check("rand_rd_data", rd, ref_mem[widx(a)]);
      end else begin
        access(1, op == 2, a, d, lat, rd);
        ref_mem[widx(a)] = d;
        check("rand_wr_latency", lat, 3);
        check("rand_wr_hw_lo", sram_mem[8'(exp_half(a, 0))], d[15:0]);
        check("rand_wr_hw_hi", sram_mem[8'(exp_half(a, 1))], d[31:16]);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
